// File: rtl/ir_key_event_queue_if.sv
// ----------------------------------------------------------------------------
// ir_key_event_queue_if
//   Key-event stream between the IR key event queue and its consumer
//   (host / LED logic). First-word-fall-through valid/ready handshake.
//
//   evt_valid  head entry present
//   evt_ready  consumer accepts the head entry when evt_valid & evt_ready
//   evt_key    head entry key code (0 when empty)
//   evt_type   head entry type: 00 PRESS, 01 REPEAT, 10 RELEASE (0 when empty)
//
//   master : the queue (drives valid/key/type)
//   slave  : the consumer (drives ready)
// ----------------------------------------------------------------------------
interface ir_key_event_queue_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_key;
  logic [1:0] evt_type;

  modport master (
    output evt_valid,
    output evt_key,
    output evt_type,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_key,
    input  evt_type,
    output evt_ready
  );
endinterface

// File: rtl/ir_key_event_queue.sv
// ----------------------------------------------------------------------------
// ir_key_event_queue
//   Sits behind the NEC IR frame decoder. Each rising edge of frame_valid
//   delivers one decoded frame; the key FSM turns frames into PRESS / REPEAT /
//   RELEASE events, which are buffered in a small FIFO for the consumer.
//   Frames from other remotes can optionally be filtered by address.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   frame_valid  decoder ready level; only its 0->1 transition starts a frame
//   frame_data   [31:24] ~key, [23:16] key, [15:0] remote address
//   evt          event stream (master side of ir_key_event_queue_if)
//   fifo_level   current FIFO occupancy
//   overflow     sticky: an event was dropped because the FIFO was full
//   ovf_clr      synchronous clear of overflow and drop_cnt
//   drop_cnt     dropped-event count, saturating at 255
//
// Pipeline
//   edge E   : frame_valid=1 and fv_q=0 detected
//   edge E+1 : frame_data sampled, address filter applied
//   edge E+2 : key FSM acts, event written into the FIFO
// ----------------------------------------------------------------------------
module ir_key_event_queue #(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned TIMER_W         = 24,
  parameter int unsigned HOLD_WINDOW     = 6000000,
  parameter int unsigned RELEASE_TIMEOUT = 7500000,
  parameter int unsigned ADDR_FILTER_EN  = 0,
  parameter logic [15:0] ADDR_MATCH      = 16'h0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_valid,
  input  logic [31:0]                   frame_data,
  ir_key_event_queue_if.master          evt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [7:0]                    drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [TIMER_W-1:0] HOLD_LIM = TIMER_W'(HOLD_WINDOW);
  localparam logic [TIMER_W-1:0] REL_LAST = TIMER_W'(RELEASE_TIMEOUT - 1);

  typedef enum logic {
    KEY_IDLE,
    KEY_HELD
  } key_state_t;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_REPEAT  = 2'b01,
    EVT_RELEASE = 2'b10
  } evt_type_t;

  typedef struct packed {
    evt_type_t  etype;
    logic [7:0] key;
  } evt_t;

  // --------------------------------------------------------------------------
  // Frame edge detect and capture
  // --------------------------------------------------------------------------
  logic       fv_q;
  logic       cap_pend;   // high for the cycle after edge E: sample data now
  logic       frm_go;     // accepted frame ready for the key FSM
  logic [7:0] frm_key;
  logic       addr_ok;

  // The inverted key byte is validated by the decoder; it is not needed here.
  logic unused_inv_key;
  assign unused_inv_key = ^frame_data[31:24];

  assign addr_ok = (ADDR_FILTER_EN == 0) || (frame_data[15:0] == ADDR_MATCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q     <= 1'b0;
      cap_pend <= 1'b0;
      frm_go   <= 1'b0;
      frm_key  <= '0;
    end else begin
      fv_q     <= frame_valid;
      cap_pend <= frame_valid & ~fv_q;
      // A filtered frame simply never reaches the FSM, so state and timer
      // are left exactly as they were.
      frm_go   <= cap_pend & addr_ok;
      if (cap_pend) begin
        frm_key <= frame_data[23:16];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Key FSM
  // --------------------------------------------------------------------------
  key_state_t         state, state_nxt;
  logic [7:0]         held_key, held_key_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic               push;
  evt_t               push_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= KEY_IDLE;
      held_key <= '0;
      timer    <= '0;
    end else begin
      state    <= state_nxt;
      held_key <= held_key_nxt;
      timer    <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    held_key_nxt   = held_key;
    timer_nxt      = timer;
    push           = 1'b0;
    push_evt.etype = EVT_PRESS;
    push_evt.key   = frm_key;

    case (state)
      KEY_IDLE: begin
        if (frm_go) begin
          push         = 1'b1;
          held_key_nxt = frm_key;
          timer_nxt    = '0;
          state_nxt    = KEY_HELD;
        end
      end

      KEY_HELD: begin
        // A frame takes priority over the release timeout in the same cycle.
        if (frm_go) begin
          push         = 1'b1;
          held_key_nxt = frm_key;
          timer_nxt    = '0;
          if ((frm_key == held_key) && (timer < HOLD_LIM)) begin
            push_evt.etype = EVT_REPEAT;
          end
        end else if (timer == REL_LAST) begin
          push           = 1'b1;
          push_evt.etype = EVT_RELEASE;
          push_evt.key   = held_key;
          timer_nxt      = '0;
          state_nxt      = KEY_IDLE;
        end else if (timer != '1) begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end

      default: begin
        state_nxt = KEY_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Event FIFO (first-word fall-through)
  // --------------------------------------------------------------------------
  evt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          nonempty;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop;
  evt_t          head;

  assign nonempty = (level != '0);
  assign full     = (level == LW'(FIFO_DEPTH));
  assign pop      = nonempty & evt.evt_ready;
  // When full, a simultaneous pop frees the slot the push needs.
  assign do_push  = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_evt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    evt.evt_valid = nonempty;
    evt.evt_key   = '0;
    evt.evt_type  = '0;
    if (nonempty) begin
      evt.evt_key  = head.key;
      evt.evt_type = head.etype;
    end
  end

  assign fifo_level = level;

  // --------------------------------------------------------------------------
  // Overflow bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      // A drop coinciding with a clear restarts the count at one.
      overflow <= 1'b1;
      if (ovf_clr) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ir_key_event_queue.sv
module tb_ir_key_event_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_valid = 1'b0;
  logic [31:0] frame_data = '0;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        ovf_clr = 1'b0;
  logic [7:0]  drop_cnt;

  logic        frame_valid2 = 1'b0;
  logic [31:0] frame_data2 = '0;
  logic [3:0]  fifo_level2;
  logic        overflow2;
  logic        ovf_clr2 = 1'b0;
  logic [7:0]  drop_cnt2;

  ir_key_event_queue_if evt_if ();
  ir_key_event_queue_if evt_if2 ();

  ir_key_event_queue #(
    .FIFO_DEPTH(8), .TIMER_W(24), .HOLD_WINDOW(100), .RELEASE_TIMEOUT(150),
    .ADDR_FILTER_EN(0), .ADDR_MATCH(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_data(frame_data),
    .evt(evt_if), .fifo_level(fifo_level), .overflow(overflow),
    .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  ir_key_event_queue #(
    .FIFO_DEPTH(8), .TIMER_W(24), .HOLD_WINDOW(100), .RELEASE_TIMEOUT(150),
    .ADDR_FILTER_EN(1), .ADDR_MATCH(16'h00FF)
  ) dut_flt (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid2), .frame_data(frame_data2),
    .evt(evt_if2), .fifo_level(fifo_level2), .overflow(overflow2),
    .ovf_clr(ovf_clr2), .drop_cnt(drop_cnt2)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Popped events of the unfiltered instance, stamped with the push edge.
  int         mon_cyc[$];
  logic [7:0] mon_key[$];
  logic [1:0] mon_type[$];

  always @(negedge clk) begin
    #1;
    if (evt_if.evt_valid && evt_if.evt_ready) begin
      mon_cyc.push_back(cyc);
      mon_key.push_back(evt_if.evt_key);
      mon_type.push_back(evt_if.evt_type);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_evt(input string tag, input int idx, input int ecyc,
                            input logic [7:0] ek, input logic [1:0] et);
    int         c = -1;
    logic [7:0] k = 8'hxx;
    logic [1:0] t = 2'bxx;
    if (idx < mon_cyc.size()) begin
      c = mon_cyc[idx];
      k = mon_key[idx];
      t = mon_type[idx];
    end
    if (ecyc >= 0) check({tag, "_cyc"}, c, ecyc);
    check({tag, "_key"}, {24'h0, k}, {24'h0, ek});
    check({tag, "_type"}, {30'h0, t}, {30'h0, et});
  endtask

  task automatic clear_mon();
    mon_cyc.delete();
    mon_key.delete();
    mon_type.delete();
  endtask

  // Caller must be at a negedge; the rise happens right away.
  task automatic frame_pulse(input logic [31:0] d, input int hold, output int t);
    frame_data  = d;
    frame_valid = 1'b1;
    t = cyc;
    repeat (hold) @(negedge clk);
    frame_valid = 1'b0;
  endtask

  int t, t1, t9;

  initial begin
    evt_if.evt_ready  = 1'b1;
    evt_if2.evt_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_key", evt_if.evt_key, 0);
    check("rst_type", evt_if.evt_type, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: long-held frame -> one PRESS, evt_valid 3 edges after the rise
    clear_mon();
    frame_data  = 32'hE51A_00FF;
    frame_valid = 1'b1;
    t = cyc;
    @(negedge clk); check("t1_valid_e0", evt_if.evt_valid, 0);
    @(negedge clk); check("t1_valid_e1", evt_if.evt_valid, 0);
    @(negedge clk); check("t1_valid_e2", evt_if.evt_valid, 1);
    check("t1_head_key", evt_if.evt_key, 8'h1A);
    check("t1_head_type", evt_if.evt_type, 2'b00);
    repeat (497) @(negedge clk);
    frame_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("t1_nevt", mon_cyc.size(), 2);
    expect_evt("t1_press", 0, t + 3, 8'h1A, 2'b00);
    expect_evt("t1_rel", 1, t + 153, 8'h1A, 2'b10);

    // 2: repeat 80 cycles later, release 150 after the last frame
    clear_mon();
    frame_pulse(32'hE51A_00FF, 4, t);
    while (cyc < t + 80) @(negedge clk);
    frame_pulse(32'hE51A_00FF, 4, t1);
    repeat (170) @(negedge clk);
    check("t2_nevt", mon_cyc.size(), 3);
    expect_evt("t2_press", 0, t + 3, 8'h1A, 2'b00);
    expect_evt("t2_rep", 1, t + 83, 8'h1A, 2'b01);
    expect_evt("t2_rel", 2, t + 233, 8'h1A, 2'b10);

    // 2b: hold window boundary: timer 99 -> REPEAT, timer 100 -> PRESS
    clear_mon();
    frame_pulse(32'hE51A_00FF, 4, t);
    while (cyc < t + 100) @(negedge clk);
    frame_pulse(32'hE51A_00FF, 4, t1);
    while (cyc < t + 201) @(negedge clk);
    frame_pulse(32'hE51A_00FF, 4, t1);
    repeat (170) @(negedge clk);
    check("t2b_nevt", mon_cyc.size(), 4);
    expect_evt("t2b_press", 0, t + 3, 8'h1A, 2'b00);
    expect_evt("t2b_rep99", 1, t + 103, 8'h1A, 2'b01);
    expect_evt("t2b_press100", 2, t + 204, 8'h1A, 2'b00);
    expect_evt("t2b_rel", 3, t + 354, 8'h1A, 2'b10);

    // 3: key change -> PRESS new key, no RELEASE for the old one
    clear_mon();
    frame_pulse(32'hE51A_00FF, 4, t);
    while (cyc < t + 50) @(negedge clk);
    frame_pulse(32'hBA45_00FF, 4, t1);
    repeat (170) @(negedge clk);
    check("t3_nevt", mon_cyc.size(), 3);
    expect_evt("t3_press1a", 0, t + 3, 8'h1A, 2'b00);
    expect_evt("t3_press45", 1, t + 53, 8'h45, 2'b00);
    expect_evt("t3_rel45", 2, t + 203, 8'h45, 2'b10);

    // 4: address filter drops foreign frames and leaves the FSM idle
    frame_data2  = 32'hFD02_0102;
    frame_valid2 = 1'b1;
    repeat (4) @(negedge clk);
    frame_valid2 = 1'b0;
    repeat (40) @(negedge clk);
    check("t4_flt_level", fifo_level2, 0);
    check("t4_flt_valid", evt_if2.evt_valid, 0);
    frame_data2  = 32'hFD02_00FF;
    frame_valid2 = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_acc_valid", evt_if2.evt_valid, 1);
    check("t4_acc_key", evt_if2.evt_key, 8'h02);
    check("t4_acc_type", evt_if2.evt_type, 2'b00);
    frame_valid2 = 1'b0;
    repeat (200) @(negedge clk);
    check("t4_acc_level", fifo_level2, 2);

    // 5: overflow with evt_ready low
    evt_if.evt_ready = 1'b0;
    clear_mon();
    for (int k = 1; k <= 9; k++) begin
      logic [7:0] kk;
      kk = 8'(k);
      frame_pulse({~kk, kk, 16'h00FF}, 2, t);
      if (k == 1) t1 = t;
      if (k == 9) t9 = t;
      repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("t5_level", fifo_level, 8);
    check("t5_ovf", overflow, 1);
    check("t5_drop", drop_cnt, 1);
    check("t5_head_key", evt_if.evt_key, 8'h01);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t5_clr_ovf", overflow, 0);
    check("t5_clr_drop", drop_cnt, 0);
    check("t5_clr_level", fifo_level, 8);
    evt_if.evt_ready = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_nevt", mon_cyc.size(), 8);
    for (int k = 0; k < 8; k++) begin
      expect_evt($sformatf("t5_fifo%0d", k), k, -1, 8'(k + 1), 2'b00);
    end
    check("t5_drained", fifo_level, 0);
    while (cyc < t9 + 160) @(negedge clk);
    check("t5_nevt_rel", mon_cyc.size(), 9);
    expect_evt("t5_rel9", 8, t9 + 153, 8'h09, 2'b10);
    check("t5_ovf_after", overflow, 0);

    // 6: reset while held with three queued events
    evt_if.evt_ready = 1'b0;
    clear_mon();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] kk;
      kk = 8'(8'h21 + k);
      frame_pulse({~kk, kk, 16'h00FF}, 2, t);
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("t6_level_pre", fifo_level, 3);
    rst_n = 1'b0;
    #1;
    check("t6_valid_in_rst", evt_if.evt_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_valid", evt_if.evt_valid, 0);
    check("t6_level", fifo_level, 0);
    check("t6_key", evt_if.evt_key, 0);
    evt_if.evt_ready = 1'b1;
    repeat (200) @(negedge clk);
    check("t6_no_release", mon_cyc.size(), 0);
    check("t6_level_end", fifo_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
